// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the instruction fetch sequencer of the 16-bit CPU:
//   - fetch_state_e    : fetch FSM state encoding (IDLE, RUN, HALT)
//   - OPC_MSB/OPC_LSB  : position of the opcode field inside an instruction
//   - HALT_OPC_DEFAULT : opcode value that stops fetching
// No ports; imported by fetch_sequencer with import fetch_pkg::*.
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam logic [3:0] HALT_OPC_DEFAULT = 4'hF;

endpackage

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer
// ----------------------------------------------------------------------------
// Drives the combinational instruction memory of the 16-bit CPU and hands
// each returned instruction to decode through a registered valid/ready stage.
// Owns the program counter, handles start, branch/jump redirect (with flush
// of the output stage) and stops fetching when a halt opcode is captured.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle pulse, leaves IDLE and begins fetching
//   imem_addr      out  address to instruction memory (current PC)
//   imem_data      in   instruction returned for imem_addr, same cycle
//   redirect_valid in   branch/jump taken this cycle
//   redirect_pc    in   target PC, used when redirect_valid is high
//   if_valid       out  output stage holds an instruction
//   if_ready       in   decode accepts the instruction this cycle
//   if_ins         out  registered instruction
//   if_pc          out  PC of if_ins
//   halted         out  high while fetching is stopped by a halt opcode
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   cnt_clr        in   synchronous clear of fetch_count (beats increment)
//   fetch_count    out  saturating count of accepted instructions
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INS_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OPC = HALT_OPC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_data,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [INS_W-1:0] if_ins,
    output logic [PC_W-1:0]  if_pc,
    output logic             halted
`ifdef FETCH_PERF_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [15:0]      fetch_count
`endif
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic             valid_q;
    logic             valid_d;
    logic [INS_W-1:0] ins_q;
    logic [INS_W-1:0] ins_d;
    logic [PC_W-1:0]  ins_pc_q;
    logic [PC_W-1:0]  ins_pc_d;
    logic             load;
    logic             is_halt_op;

    // The memory is combinational, so the address is simply the current PC
    // and the output stage mirrors the registered copies.
    assign imem_addr = pc_q;
    assign if_valid  = valid_q;
    assign if_ins    = ins_q;
    assign if_pc     = ins_pc_q;
    assign halted    = (state_q == HALT);

    // A new instruction may enter the output stage only while running and
    // only when the stage is empty or being drained this very cycle.
    assign load       = (state_q == RUN) && (!valid_q || if_ready);
    assign is_halt_op = (imem_data[OPC_MSB:OPC_LSB] == HALT_OPC);

    // All fetch state lives in one register bank; it returns to reset values
    // immediately on rst_n, discarding whatever instruction was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            ins_q    <= '0;
            ins_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            ins_q    <= ins_d;
            ins_pc_q <= ins_pc_d;
        end
    end

    // Next-state and datapath decisions. In RUN a redirect outranks
    // everything: it flushes the output stage and suppresses any capture,
    // including a halt opcode sitting on the memory bus. A captured halt is
    // still delivered to decode, but the PC freezes on it. Outside RUN the
    // stage can only drain.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        ins_d    = ins_q;
        ins_pc_d = ins_pc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
                if (valid_q && if_ready) begin
                    valid_d = 1'b0;
                end
            end

            RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (load) begin
                    ins_d    = imem_data;
                    ins_pc_d = pc_q;
                    valid_d  = 1'b1;
                    if (is_halt_op) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end

            HALT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = RUN;
                end
                if (valid_q && if_ready) begin
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    // Counts instructions handed to decode. Clearing beats counting, and the
    // count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 16'h0000;
        end else if (cnt_clr) begin
            fetch_count <= 16'h0000;
        end else if (valid_q && if_ready && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// tb_fetch_sequencer
// ----------------------------------------------------------------------------
// Bench for fetch_sequencer with an instruction memory array answering the
// DUT address combinationally. Directed vectors cover the start/fetch/halt
// stream, stalls, redirect flush, PC wrap and redirect-over-halt; a short
// sequence covers reset mid-stream; then random traffic is checked against a
// behavioural model. Honours FETCH_PERF_CNT_EN for the counter ports.
// ============================================================================
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_ins;
    logic [15:0] if_pc;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic        cnt_clr;
    logic [15:0] fetch_count;
`endif

    logic [15:0] instruction_memory [0:65535];

    int n_compared;
    int n_mismatched;

    typedef struct {
        bit          reset_first;
        bit          start;
        bit          ready;
        bit          redir;
        logic [15:0] rpc;
        bit          exp_valid;
        logic [15:0] exp_ins;
        logic [15:0] exp_pc;
        logic [15:0] exp_addr;
        bit          exp_halted;
    } vec_t;

    vec_t vectors [25];

    // Behavioural model state: whether fetching has been started, whether a
    // halt opcode stopped it, and what decode currently sees.
    bit m_started;
    bit m_halted;
    int m_pc;
    bit m_valid;
    logic [15:0] m_ins;
    int m_out_pc;
    int m_count;

    assign imem_data = instruction_memory[imem_addr];

    fetch_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_ins        (if_ins),
        .if_pc         (if_pc),
        .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .cnt_clr       (cnt_clr),
        .fetch_count   (fetch_count)
`endif
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic doReset();
        start          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
`ifdef FETCH_PERF_CNT_EN
        cnt_clr        = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.reset_first) doReset();
        start          = v.start;
        if_ready       = v.ready;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
    endtask

    task automatic checkVector(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        checkOutput({tag, ".if_valid"}, 16'(if_valid), 16'(v.exp_valid));
        checkOutput({tag, ".if_ins"}, if_ins, v.exp_ins);
        checkOutput({tag, ".if_pc"}, if_pc, v.exp_pc);
        checkOutput({tag, ".imem_addr"}, imem_addr, v.exp_addr);
        checkOutput({tag, ".halted"}, 16'(halted), 16'(v.exp_halted));
    endtask

    // Advances the model by one clock edge from the inputs currently driven.
    task automatic modelStep();
        bit handshake;
        handshake = m_valid && (if_ready === 1'b1);
        if (!m_started) begin
            if (start) m_started = 1'b1;
            if (handshake) m_valid = 1'b0;
        end else if (m_halted) begin
            if (redirect_valid) begin
                m_pc     = int'(redirect_pc);
                m_halted = 1'b0;
            end
            if (handshake) m_valid = 1'b0;
        end else begin
            if (redirect_valid) begin
                m_pc    = int'(redirect_pc);
                m_valid = 1'b0;
            end else if (!m_valid || if_ready) begin
                m_ins    = instruction_memory[m_pc];
                m_out_pc = m_pc;
                m_valid  = 1'b1;
                if ((m_ins >> 12) == 16'hF) m_halted = 1'b1;
                else m_pc = (m_pc + 1) % 65536;
            end
        end
`ifdef FETCH_PERF_CNT_EN
        if (cnt_clr) m_count = 0;
        else if (handshake && m_count < 65535) m_count = m_count + 1;
`endif
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b1;
        start        = 1'b0;
        if_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc  = 16'h0000;
`ifdef FETCH_PERF_CNT_EN
        cnt_clr      = 1'b0;
`endif
        m_count = 0;

        for (int a = 0; a < 65536; a++) instruction_memory[a] = 16'h0000;
        instruction_memory[16'h0000] = 16'h1001;
        instruction_memory[16'h0001] = 16'h2002;
        instruction_memory[16'h0002] = 16'h3003;
        instruction_memory[16'h0003] = 16'h4004;
        instruction_memory[16'h0004] = 16'hF000;
        instruction_memory[16'h0010] = 16'h5010;
        instruction_memory[16'hFFFF] = 16'h6FFF;
        instruction_memory[16'h0020] = 16'hF000;
        instruction_memory[16'h0030] = 16'h7030;
        instruction_memory[16'h0031] = 16'hF000;

        // {reset_first, start, ready, redir, rpc, exp_valid, exp_ins, exp_pc, exp_addr, exp_halted}
        vectors = '{
            '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1001, 16'h0000, 16'h0001, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h2002, 16'h0001, 16'h0002, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3003, 16'h0002, 16'h0003, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h4004, 16'h0003, 16'h0004, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hF000, 16'h0004, 16'h0004, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hF000, 16'h0004, 16'h0004, 1'b1},
            '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hF000, 16'h0004, 16'h0004, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1001, 16'h0000, 16'h0001, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h2002, 16'h0001, 16'h0002, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2002, 16'h0001, 16'h0002, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2002, 16'h0001, 16'h0002, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2002, 16'h0001, 16'h0002, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3003, 16'h0002, 16'h0003, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h3003, 16'h0002, 16'h0010, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h5010, 16'h0010, 16'h0011, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h5010, 16'h0010, 16'hFFFF, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h6FFF, 16'hFFFF, 16'h0000, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 1'b0, 16'h6FFF, 16'hFFFF, 16'h0020, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0030, 1'b0, 16'h6FFF, 16'hFFFF, 16'h0030, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h7030, 16'h0030, 16'h0031, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hF000, 16'h0031, 16'h0031, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'hF000, 16'h0031, 16'h0000, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1001, 16'h0000, 16'h0001, 1'b0}
        };

        // Directed vectors: one clock edge each, checked 1 unit later.
        for (int i = 0; i < 25; i++) begin
            applyStimulus(vectors[i]);
            if (vectors[i].reset_first) begin
                checkOutput($sformatf("vec%0d.reset_valid", i), 16'(if_valid), 16'h0000);
                checkOutput($sformatf("vec%0d.reset_addr", i), imem_addr, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
                checkOutput($sformatf("vec%0d.reset_count", i), fetch_count, 16'h0000);
`endif
            end
            @(posedge clk);
            #1;
            checkVector(vectors[i], i);
`ifdef FETCH_PERF_CNT_EN
            if (i == 7) checkOutput("fetch_count_after_stream", fetch_count, 16'd5);
`endif
        end

        // Reset asserted mid-stream: outputs clear at once, start is ignored
        // while reset is held and the sequencer stays idle afterwards.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset.if_valid", 16'(if_valid), 16'h0000);
        checkOutput("midreset.imem_addr", imem_addr, 16'h0000);
        checkOutput("midreset.if_ins", if_ins, 16'h0000);
        checkOutput("midreset.if_pc", if_pc, 16'h0000);
        checkOutput("midreset.halted", 16'(halted), 16'h0000);
        start          = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("inreset.if_valid", 16'(if_valid), 16'h0000);
        checkOutput("inreset.imem_addr", imem_addr, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("postreset_idle.if_valid", 16'(if_valid), 16'h0000);
        checkOutput("postreset_idle.imem_addr", imem_addr, 16'h0000);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("restart.if_valid", 16'(if_valid), 16'h0001);
        checkOutput("restart.if_ins", if_ins, 16'h1001);
        checkOutput("restart.imem_addr", imem_addr, 16'h0001);

        // Random traffic against the behavioural model.
        for (int a = 0; a < 65536; a++) instruction_memory[a] = 16'($urandom);
        doReset();
        m_started = 1'b0;
        m_halted  = 1'b0;
        m_pc      = 0;
        m_valid   = 1'b0;
        m_ins     = 16'h0000;
        m_out_pc  = 0;
        m_count   = 0;
        for (int c = 0; c < 3000; c++) begin
            start          = ($urandom_range(0, 15) == 0);
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFFD + 16'($urandom_range(0, 2));
            else redirect_pc = 16'($urandom);
`ifdef FETCH_PERF_CNT_EN
            cnt_clr = ($urandom_range(0, 63) == 0);
`endif
            modelStep();
            @(posedge clk);
            #1;
            checkOutput("rand.if_valid", 16'(if_valid), 16'(m_valid));
            checkOutput("rand.if_ins", if_ins, m_ins);
            checkOutput("rand.if_pc", if_pc, 16'(m_out_pc));
            checkOutput("rand.imem_addr", imem_addr, 16'(m_pc));
            checkOutput("rand.halted", 16'(halted), 16'(m_halted && m_started));
`ifdef FETCH_PERF_CNT_EN
            checkOutput("rand.fetch_count", fetch_count, 16'(m_count));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the combinational instruction memory for the 16-bit CPU.
- Owns the program counter and drives the memory address.
- Captures the returned instruction into a registered valid/ready output stage for decode.
- Handles start, branch/jump redirect with flush, and halt detection; sits between instructionMemory and the decode/control stage.

Parameters:
- PC_W, 16: program counter and memory address width (word-addressed).
- INS_W, 16: instruction width.
- RESET_PC, 16'h0000: PC value loaded on reset.
- HALT_OPC, 4'hF: opcode value in ins[15:12] that halts fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; leaves IDLE and begins fetching.
- imem_addr  out  PC_W  address to instruction memory (pc input); equals pc_q, combinational.
- imem_data  in  INS_W  instruction from memory (ins output); valid in the same cycle as imem_addr.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  PC_W  target PC, sampled when redirect_valid=1.
- if_valid  out  1  output stage holds an instruction.
- if_ready  in  1  decode accepts the instruction this cycle.
- if_ins  out  INS_W  registered instruction.
- if_pc  out  PC_W  PC of if_ins.
- halted  out  1  high while in HALT.

Behaviour:
- Reset: async on rst_n=0. state=IDLE, pc_q=RESET_PC, if_valid=0, if_ins=0, if_pc=0, halted=0.
- States:
  - IDLE: start=1 -> RUN. redirect is ignored in IDLE.
  - RUN: fetch as below.
  - HALT: no fetch; pc_q holds; halted=1. redirect_valid=1 -> pc_q<=redirect_pc, RUN. start is ignored.
- Load condition: load = (state==RUN) && (!if_valid || if_ready).
- Normal fetch on load:
  - if_ins<=imem_data, if_pc<=pc_q, if_valid<=1.
  - pc_q<=pc_q+1 modulo 2^PC_W; 16'hFFFF wraps to 16'h0000 with no flag.
- Latency: the instruction at address A appears on if_ins one cycle after pc_q==A.
- Throughput: one instruction per cycle while if_ready=1.
- Stall: if_valid=1 and if_ready=0 -> pc_q, if_ins, if_pc hold stable.
- Consume without load: if_valid=1, if_ready=1 and not RUN -> if_valid<=0.
- Redirect in RUN (highest priority):
  - pc_q<=redirect_pc and if_valid<=0 (flush), regardless of if_ready or load.
  - The instruction at redirect_pc is presented on the following cycle.
- Halt: when load captures imem_data[15:12]==HALT_OPC:
  - The halt instruction is delivered normally (if_valid<=1).
  - pc_q is not incremented; state<=HALT.
  - if_valid drops after decode accepts it.
- Redirect and halt capture in the same cycle: redirect wins; no halt, no capture.
- start during RUN or HALT: no effect.
- rst_n asserted mid-operation: immediate return to reset values; any in-flight instruction is discarded.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count [15:0] and input cnt_clr.
  - fetch_count increments on each if_valid&&if_ready handshake and saturates at 16'hFFFF.
  - cnt_clr=1 zeroes it synchronously; cnt_clr has priority over increment.
  - fetch_count resets to 0.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Shared package/header fetch_pkg: state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2), opcode field slice constants (OPC_MSB=15, OPC_LSB=12), HALT_OPC default.
- No sub-module; the saturating counter stays inline under FETCH_PERF_CNT_EN.
- Bench instantiates fetch_sequencer with instructionMemory.

Test Plan:
- Reset, then start, memory {0x1001,0x2002,0x3003,0x4004,0xF000}, if_ready=1 -> if_ins sequence 0x1001..0xF000 with if_pc 0..4 on consecutive cycles; halted=1 after 0xF000 accepted; pc_q stays 4.
- if_ready=0 for 3 cycles while if_ins=0x2002 -> if_ins/if_pc/imem_addr stable; next fetch is pc 2 after if_ready returns.
- redirect_valid=1, redirect_pc=0x0010 while if_valid=1 -> next cycle if_valid=0, imem_addr=0x0010; following cycle if_pc=0x0010.
- pc_q=0xFFFF in RUN -> after load, imem_addr=0x0000, if_pc=0xFFFF.
- Redirect coincident with fetching 0xF000 -> no HALT; fetch continues from redirect_pc. Redirect to 0x0000 while in HALT -> RUN, halted=0.
- rst_n low mid-stream -> if_valid=0, imem_addr=0, state IDLE; start ignored until rst_n high. With FETCH_PERF_CNT_EN, fetch_count=5 after the first scenario.
